// File: rtl/piso_tx_pkg.sv
// Shared state encoding and defaults for the PISO transmitter and its link benches.
package piso_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } piso_state_e;

  localparam int PISO_SIZE_DEFAULT = 4;

  // $clog2 that never collapses to a zero-width counter.
  function automatic int width_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, MSB-first serial
// output with an optional forced idle gap after each word.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int SIZE       = PISO_SIZE_DEFAULT,
  parameter int GAP_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] load_data,
  input  logic            load_valid,
  output logic            load_ready,
  output logic            sout,
  output logic            sout_valid,
  output logic            busy,
  output logic            done
);

  localparam int CNT_W   = width_min1(SIZE);
  localparam int GAP_W   = width_min1(GAP_CYCLES + 1);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  piso_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [SIZE-1:0]  shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q;
  logic             done_q;
  logic             accept;
  logic             start;

  // Ready while reset is held stays low so a word offered during reset is never lost silently.
  assign load_ready = !reset &&
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_SHIFT) && (cnt_q == '0) && !HAS_GAP));
  assign accept     = load_valid && load_ready;
  assign busy       = (state_q != ST_IDLE);
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    sout_d  = 1'b0;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) start = 1'b1;
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - 1'b1;
          sout_d  = shreg_q[SIZE-1];
          shreg_d = {shreg_q[SIZE-2:0], 1'b0};
        end else if (HAS_GAP) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else if (accept) begin
          start = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // The MSB goes straight to sout; the shift register keeps only the bits still to send.
    if (start) begin
      state_d = ST_SHIFT;
      cnt_d   = CNT_LAST;
      sout_d  = load_data[SIZE-1];
      shreg_d = {load_data[SIZE-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      gap_q        <= '0;
      shreg_q      <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      shreg_q      <= shreg_d;
      sout_q       <= sout_d;
      sout_valid_q <= (state_d == ST_SHIFT);
      done_q       <= (state_d == ST_SHIFT) && (cnt_d == '0);
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a gap-free and a GAP_CYCLES=2 instance, a behavioural SIPO
// on the gap-free link, directed sequences and a random phase against a cycle-schedule model.
module tb_piso_tx;
  import piso_tx_pkg::*;

  localparam int SIZE = 4;
  localparam int NCYC = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] lv = '0;
  logic [1:0][SIZE-1:0] ld = '0;
  wire  [1:0] rdy, so, sv, bsy, dn;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  piso_tx #(.SIZE(SIZE), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .load_data(ld[0]), .load_valid(lv[0]), .load_ready(rdy[0]),
    .sout(so[0]), .sout_valid(sv[0]), .busy(bsy[0]), .done(dn[0]));

  piso_tx #(.SIZE(SIZE), .GAP_CYCLES(2)) u_dut1 (
    .clk(clk), .reset(reset), .load_data(ld[1]), .load_valid(lv[1]), .load_ready(rdy[1]),
    .sout(so[1]), .sout_valid(sv[1]), .busy(bsy[1]), .done(dn[1]));

  always #5 clk = ~clk;

  // Receiving end of the gap-free link.
  logic [SIZE-1:0] sipo0;
  always @(posedge clk) begin
    if (reset)      sipo0 <= '0;
    else if (sv[0]) sipo0 <= {sipo0[SIZE-2:0], so[0]};
  end

  // Reference: per-cycle schedule of expected outputs, filled in whenever a word is accepted.
  bit exp_s [2][NCYC];
  bit exp_v [2][NCYC];
  bit exp_d [2][NCYC];
  bit exp_b [2][NCYC];
  int next_ok [2];
  int gap_of [2] = '{0, 2};

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        next_ok[d] = cyc + 1;
        for (int n = cyc; n < cyc + 16 && n < NCYC; n++) begin
          exp_s[d][n] = 0; exp_v[d][n] = 0; exp_d[d][n] = 0; exp_b[d][n] = 0;
        end
      end else if (lv[d] && cyc >= next_ok[d]) begin
        for (int k = 0; k < SIZE; k++) begin
          exp_v[d][cyc+k] = 1;
          exp_s[d][cyc+k] = ld[d][SIZE-1-k];
          exp_d[d][cyc+k] = (k == SIZE-1);
        end
        for (int k = 0; k < SIZE + gap_of[d]; k++) exp_b[d][cyc+k] = 1;
        next_ok[d] = cyc + SIZE + ((gap_of[d] > 0) ? gap_of[d] + 1 : 0);
      end
    end
  end

  task automatic check1(input string name, input int d, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d got=%b want=%b", name, d, cyc, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check1("m_sout",  d, so[d],  exp_s[d][cyc]);
        check1("m_valid", d, sv[d],  exp_v[d][cyc]);
        check1("m_done",  d, dn[d],  exp_d[d][cyc]);
        check1("m_busy",  d, bsy[d], exp_b[d][cyc]);
        check1("m_ready", d, rdy[d], !reset && (cyc + 1 >= next_ok[d]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [SIZE-1:0] word;
    logic [SIZE-1:0] exp_seq;
    logic [SIZE-1:0] exp_q;
    bit              poke;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [7:0]  seq8;
    logic [10:0] g_sv, g_so, g_rdy, g_bsy;

    tbl[0] = '{4'b1011, 4'b1011, 4'hB, 1'b0};
    tbl[1] = '{4'b0000, 4'b0000, 4'h0, 1'b1};
    tbl[2] = '{4'b1111, 4'b1111, 4'hF, 1'b1};
    tbl[3] = '{4'b0110, 4'b0110, 4'h6, 1'b0};
    tbl[4] = '{4'b1000, 4'b1000, 4'h8, 1'b1};

    // Reset held for two cycles: everything low, including ready.
    tick();
    chk_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check1("rst_sout", d, so[d], 1'b0);
        check1("rst_valid", d, sv[d], 1'b0);
        check1("rst_busy", d, bsy[d], 1'b0);
        check1("rst_done", d, dn[d], 1'b0);
        check1("rst_ready", d, rdy[d], 1'b0);
      end
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    check1("ready_after_rst", 0, rdy[0], 1'b1);
    check1("ready_after_rst", 1, rdy[1], 1'b1);

    // Single words, with data changed mid-word and ignored loads while busy.
    foreach (tbl[i]) begin
      tick();
      ld[0] = tbl[i].word;
      lv[0] = 1'b1;
      tick();
      lv[0] = 1'b0;
      ld[0] = ~tbl[i].word;
      for (int k = 0; k < SIZE; k++) begin
        @(negedge clk);
        check1("tbl_sout", 0, so[0], tbl[i].exp_seq[SIZE-1-k]);
        check1("tbl_valid", 0, sv[0], 1'b1);
        check1("tbl_done", 0, dn[0], k == SIZE-1);
        if (tbl[i].poke && k < 2) begin lv[0] = 1'b1; ld[0] = 4'h9; end
        else lv[0] = 1'b0;
        if (k < SIZE-1) tick();
      end
      tick();
      @(negedge clk);
      checkw("tbl_sipo", 8'(sipo0), 8'(tbl[i].exp_q));
      check1("tbl_idle_valid", 0, sv[0], 1'b0);
    end

    // Back-to-back A then 5 without a bubble.
    seq8 = 8'b1010_0101;
    tick();
    ld[0] = 4'hA;
    lv[0] = 1'b1;
    tick();
    ld[0] = 4'h5;
    for (int k = 0; k < 2*SIZE; k++) begin
      @(negedge clk);
      check1("b2b_sout", 0, so[0], seq8[7-k]);
      check1("b2b_valid", 0, sv[0], 1'b1);
      check1("b2b_busy", 0, bsy[0], 1'b1);
      check1("b2b_done", 0, dn[0], (k == SIZE-1) || (k == 2*SIZE-1));
      if (k == SIZE-1) check1("b2b_ready_last", 0, rdy[0], 1'b1);
      if (k == SIZE) begin
        checkw("b2b_sipo_a", 8'(sipo0), 8'h0A);
        lv[0] = 1'b0;
      end
      if (k < 2*SIZE-1) tick();
    end
    tick();
    @(negedge clk);
    checkw("b2b_sipo_5", 8'(sipo0), 8'h05);

    // Gap of two cycles, load_valid held high; second word taken in the idle cycle.
    g_sv  = 11'b1111_000_1111;
    g_so  = 11'b1100_000_0110;
    g_rdy = 11'b0000_001_0000;
    g_bsy = 11'b1111_110_1111;
    tick();
    ld[1] = 4'hC;
    lv[1] = 1'b1;
    tick();
    ld[1] = 4'h6;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      check1("gap_sout", 1, so[1], g_so[10-k]);
      check1("gap_valid", 1, sv[1], g_sv[10-k]);
      check1("gap_ready", 1, rdy[1], g_rdy[10-k]);
      check1("gap_busy", 1, bsy[1], g_bsy[10-k]);
      if (k == 7) lv[1] = 1'b0;
      tick();
    end

    // Reset mid-word aborts; a load offered during reset is dropped.
    tick();
    ld[0] = 4'hF;
    lv[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    @(negedge clk);
    check1("abort_first_bit", 0, so[0], 1'b1);
    tick();
    reset = 1'b1;
    ld[1] = 4'hF;
    lv[1] = 1'b1;
    tick();
    @(negedge clk);
    check1("abort_sout", 0, so[0], 1'b0);
    check1("abort_valid", 0, sv[0], 1'b0);
    check1("abort_busy", 0, bsy[0], 1'b0);
    check1("abort_done", 0, dn[0], 1'b0);
    tick();
    reset = 1'b0;
    lv[1] = 1'b0;
    @(negedge clk);
    check1("rst_load_dropped", 1, bsy[1], 1'b0);
    tick();
    ld[0] = 4'h3;
    lv[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    for (int k = 0; k < SIZE; k++) begin
      @(negedge clk);
      check1("after_abort_sout", 0, so[0], (k >= 2));
      check1("after_abort_done", 0, dn[0], k == SIZE-1);
      tick();
    end

    // Random traffic with occasional resets, checked by the schedule model.
    for (int n = 0; n < 800; n++) begin
      tick();
      reset = ($urandom_range(0, 63) == 0);
      for (int d = 0; d < 2; d++) begin
        lv[d] = 1'($urandom_range(0, 1));
        ld[d] = SIZE'($urandom);
      end
    end
    tick();
    reset = 1'b0;
    lv = '0;
    repeat (12) tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
